pc_trace_buffer: RTL and testbench

Non-intrusive branch-trace monitor that sits beside `yfcpu` and watches its 8-bit `pc` output. It never drives the core. It samples `pc` every cycle and records each control-flow discontinuity as a `{from_pc, to_pc}` record in a first-word-fall-through FIFO. A valid/ready read port drains the FIFO to a debug host or testbench.

---
 rtl/pc_trace_buffer_if.sv | 10 +
 rtl/pc_trace_buffer.sv | 110 +++++++++++
 tb/tb_pc_trace_buffer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pc_trace_buffer_if.sv
// Read port of the PC trace buffer: a valid/ready stream of {from_pc, to_pc} records.
// RW is 16, or 24 when the design is built with PC_TRACE_TIMESTAMP_EN.
interface pc_trace_buffer_if #(parameter int RW = 16);
  logic          rd_valid;
  logic          rd_ready;
  logic [RW-1:0] rd_data;

  modport master (output rd_valid, output rd_data, input  rd_ready);
  modport slave  (input  rd_valid, input  rd_data, output rd_ready);
endinterface

// File: rtl/pc_trace_buffer.sv
// Branch-trace monitor: records each PC discontinuity into a FWFT FIFO drained over a valid/ready port.
// Optional feature macro PC_TRACE_TIMESTAMP_EN prepends an 8-bit cycle stamp to each record.
module pc_trace_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            pc,
  input  logic                  trace_en,
  input  logic                  clr,
  pc_trace_buffer_if.master     rd,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            drop_count
);
`ifdef PC_TRACE_TIMESTAMP_EN
  localparam int RW = 24;
`else
  localparam int RW = 16;
`endif
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, PRIME, TRACE} state_t;

  state_t                r_state;
  logic [7:0]            r_last_pc;
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;
  logic [7:0]            r_drop_count;
  logic [RW-1:0]         r_mem [DEPTH];

  logic          w_disc, w_full, w_nonempty, w_pop, w_push, w_drop;
  logic [RW-1:0] w_rec;

  // Sequential includes 0xFF->0x00 because the +1 is evaluated at 8 bits.
  assign w_disc     = (r_state == TRACE) && trace_en &&
                      (pc != r_last_pc) && (pc != r_last_pc + 8'd1);
  assign w_full     = r_count[DEPTH_LOG2];
  assign w_nonempty = (r_count != '0);
  assign w_pop      = rd.rd_ready && w_nonempty;
  assign w_push     = w_disc && (!w_full || w_pop);
  assign w_drop     = w_disc && w_full && !w_pop;

`ifdef PC_TRACE_TIMESTAMP_EN
  logic [7:0] r_ts;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 r_ts <= '0;
    else if (r_state != IDLE) r_ts <= r_ts + 8'd1;
  end
  assign w_rec = {r_ts, r_last_pc, pc};
`else
  assign w_rec = {r_last_pc, pc};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_last_pc    <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      case (r_state)
        IDLE:    if (trace_en) r_state <= PRIME;
        PRIME:   if (!trace_en) r_state <= IDLE;
                 else begin r_last_pc <= pc; r_state <= TRACE; end
        TRACE:   if (!trace_en) r_state <= IDLE;
                 else r_last_pc <= pc;
        default: r_state <= IDLE;
      endcase

      // Clear wins over push/pop; the record discarded on a clear edge is not a drop.
      if (clr) begin
        r_wptr       <= '0;
        r_rptr       <= '0;
        r_count      <= '0;
        r_overflow   <= 1'b0;
        r_drop_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PTR_ONE;
        if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
        if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
      end
    end
  end

  // When full with a pop, wptr == rptr: the new tail lands in the slot being vacated.
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wptr] <= w_rec;
  end

  assign rd.rd_valid = w_nonempty;
  assign rd.rd_data  = w_nonempty ? r_mem[r_rptr] : '0;
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign drop_count  = r_drop_count;
endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed bench for pc_trace_buffer: a vector table for the basic trace flow, then
// hand-written overflow, clear, reset and (optionally) timestamp sequences.
module tb_pc_trace_buffer;
`ifdef PC_TRACE_TIMESTAMP_EN
  localparam int RW = 24;
`else
  localparam int RW = 16;
`endif
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    pc;
  logic          trace_en, clr;
  logic [DL:0]   count;
  logic          overflow;
  logic [7:0]    drop_count;

  pc_trace_buffer_if #(.RW(RW)) rif ();

  pc_trace_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .pc(pc), .trace_en(trace_en), .clr(clr),
    .rd(rif), .count(count), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]  pc;
    logic        en;
    logic        clr;
    logic        rdy;
    logic        e_valid;
    logic [15:0] e_data;
    logic [4:0]  e_count;
    logic        e_ovf;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t tv [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [15:0] d,
                         input logic [4:0] c, input logic o, input logic [7:0] dr);
    chk({tag, ".valid"}, 32'(rif.rd_valid), 32'(v));
    chk({tag, ".data"},  32'(rif.rd_data[15:0]), 32'(d));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".ovf"},   32'(overflow), 32'(o));
    chk({tag, ".drop"},  32'(drop_count), 32'(dr));
  endtask

  initial begin
    // pc, en, clr, rdy | valid, data, count, ovf, drop
    tv[0]  = '{8'h00, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // IDLE->PRIME
    tv[1]  = '{8'h00, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // PRIME loads last_pc
    tv[2]  = '{8'h01, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[3]  = '{8'h02, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[4]  = '{8'h03, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[5]  = '{8'h04, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[6]  = '{8'h05, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[7]  = '{8'h20, 1, 0, 0, 1, 16'h0520, 5'd1, 0, 8'd0}; // jump
    tv[8]  = '{8'h21, 1, 0, 1, 0, 16'h0000, 5'd0, 0, 8'd0}; // pop
    tv[9]  = '{8'hFE, 1, 0, 0, 1, 16'h21FE, 5'd1, 0, 8'd0};
    tv[10] = '{8'hFF, 1, 0, 1, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[11] = '{8'h00, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // wrap
    tv[12] = '{8'h00, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // stall
    tv[13] = '{8'h01, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[14] = '{8'h80, 1, 0, 0, 1, 16'h0180, 5'd1, 0, 8'd0};
    tv[15] = '{8'h81, 1, 0, 1, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[16] = '{8'h90, 0, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // disable
    tv[17] = '{8'hA0, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // IDLE->PRIME
    tv[18] = '{8'hB0, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0}; // PRIME, no record
    tv[19] = '{8'hB1, 1, 0, 0, 0, 16'h0000, 5'd0, 0, 8'd0};
    tv[20] = '{8'h10, 1, 0, 0, 1, 16'hB110, 5'd1, 0, 8'd0};
    tv[21] = '{8'h11, 1, 0, 1, 0, 16'h0000, 5'd0, 0, 8'd0};

    rst = 1'b0; pc = 8'h00; trace_en = 1'b0; clr = 1'b0; rif.rd_ready = 1'b0;
    #1;
    chk_all("reset", 0, 16'h0000, 5'd0, 0, 8'd0);
    step();
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      pc = tv[i].pc; trace_en = tv[i].en; clr = tv[i].clr; rif.rd_ready = tv[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_data,
              tv[i].e_count, tv[i].e_ovf, tv[i].e_drop);
    end

    // Overflow: 17 jumps into a 16-deep FIFO with no reads.
    rif.rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pc = 8'(8'h40 + 2 * i);
      step();
    end
    chk_all("ovf17", 1, 16'h1140, 5'd16, 1, 8'd1);
    pc = 8'h70; rif.rd_ready = 1'b1;
    step();
    chk_all("ovf_fullpop", 1, 16'h4042, 5'd16, 1, 8'd1);
    for (int i = 0; i < 15; i++) step();
    rif.rd_ready = 1'b0;
    chk_all("ovf_tail", 1, 16'h6070, 5'd1, 1, 8'd1);
    rif.rd_ready = 1'b1;
    step();
    rif.rd_ready = 1'b0;
    chk_all("ovf_drain", 0, 16'h0000, 5'd0, 1, 8'd1);

    // Clear with 5 records; the jump on the clear edge is discarded.
    pc = 8'h10; step();
    pc = 8'h20; step();
    pc = 8'h30; step();
    pc = 8'h40; step();
    pc = 8'h50; step();
    chk_all("pre_clr", 1, 16'h7010, 5'd5, 1, 8'd1);
    pc = 8'h60; clr = 1'b1;
    step();
    clr = 1'b0;
    chk_all("clr", 0, 16'h0000, 5'd0, 0, 8'd0);
    pc = 8'h61;
    step();
    chk_all("post_clr", 0, 16'h0000, 5'd0, 0, 8'd0);

    // Asynchronous reset mid-burst, then PRIME swallows the first pc.
    pc = 8'h10; step();
    pc = 8'h20; step();
    pc = 8'h30; step();
    chk("burst.count", 32'(count), 32'd3);
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 16'h0000, 5'd0, 0, 8'd0);
    #1 rst = 1'b1; pc = 8'h05; trace_en = 1'b1;
    step();
    chk("rel.idle.count", 32'(count), 32'd0);
    pc = 8'h30; step();
    chk("rel.prime.count", 32'(count), 32'd0);
    pc = 8'h31; step();
    chk("rel.seq.count", 32'(count), 32'd0);
    pc = 8'h90; step();
    chk_all("rel.jump", 1, 16'h3190, 5'd1, 0, 8'd0);

`ifdef PC_TRACE_TIMESTAMP_EN
    rst = 1'b0; trace_en = 1'b0;
    #1 rst = 1'b1; trace_en = 1'b1; pc = 8'h10;
    step();                              // enters PRIME
    for (int i = 1; i < 10; i++) step(); // edges 1..9 in PRIME/TRACE
    pc = 8'h40;
    step();                              // edge 10 pushes
    chk("ts.data", 32'(rif.rd_data), 32'h091040);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
